rr_encoder_4x2: RTL and testbench
=================================

Name: rr_encoder_4x2

Overview:
- Registered 4-to-2 encoder with a valid/ack output handshake. It is the inverse of the team's 2x4 line decoder.
- Samples a 4-bit request vector and reports one asserted line as a 2-bit index.
- Optionally rotates priority round-robin so no line starves.
- Sits between request/interrupt lines and a consumer that drives the 2x4 decoder to return a one-hot grant.

Parameters:
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, index 3 highest.
- PTR_RESET, 0, 2-bit starting search index after reset (round-robin mode only).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; bit k = line k.
- code  output  2  encoded index of the captured request.
- valid  output  1  code/multi hold a captured request.
- ack  input  1  consumer accepts the current code; meaningful only while valid=1.
- multi  output  1  more than one req bit was set at capture.
- ptr  output  2  current round-robin search start (debug/verification).

Behaviour:
- Reset (rst_n=0, async): code=2'b00, valid=0, multi=0, ptr=PTR_RESET. Reset overrides everything, including a transfer mid-handshake; the pending result is discarded.
- Registers:
  - code, valid, multi, ptr.
  - A single capture register, no FIFO.
  - All outputs come straight from flops; no combinational path from req or ack to any output.
- Capture condition: the slot is free (valid=0, or valid=1 && ack=1) and req != 4'b0000.
  - On that rising edge: code = selected index, multi = (popcount(req) > 1), valid=1.
  - Latency is 1 cycle from req to valid.
- Selection, ROUND_ROBIN=1:
  - Scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
  - On capture, ptr = winner+1 mod 4, so 3 wraps to 0.
- Selection, ROUND_ROBIN=0:
  - Highest set index wins: 3>2>1>0.
  - ptr is held at PTR_RESET.
- Hold: while valid=1 && ack=0, code and multi are stable and req changes are ignored. No pulse-catching, so a request that deasserts before capture is lost.
- Release: on valid=1 && ack=1 with req=0, valid goes to 0 next edge. code and multi keep their last values and are don't-care.
- Back-to-back: valid=1 && ack=1 with req!=0 captures the new request on the same edge. valid stays 1 and throughput is 1 per cycle.
- ack while valid=0 is ignored, with no state change.
- Idle with req=0: no change; ptr does not advance.
- Encoding is consistent with the 2x4 decoder: a single-hot req with bit k set gives code=k, so decoding code reproduces req.

Test Plan:
- Reset/single-hot:
  - Stimulus: assert rst_n=0 mid-run, then release; then one request per cycle with ack=1: req=0001, 0010, 0100, 1000.
  - Required: during reset, valid=0, code=00, multi=0, ptr=PTR_RESET immediately, without waiting for a clock.
  - Required: after release, code=00, 01, 10, 11 one cycle after each req; multi=0; valid held 1 throughout.
- Fixed priority (ROUND_ROBIN=0):
  - Stimulus: req=1010, ack=1.
  - Required: code=11, multi=1, every capture.
- Round-robin fairness (ROUND_ROBIN=1, PTR_RESET=0):
  - Stimulus: req=1111 held, ack=1.
  - Required: code sequence 00, 01, 10, 11, 00; ptr 1, 2, 3, 0, 1; multi=1.
  - Stimulus: req=1001 held.
  - Required: grants alternate 00, 11.
- Backpressure:
  - Stimulus: capture req=0100, then ack=0 for 5 cycles while req toggles 0001/1000.
  - Required: code=10 and valid=1 stay stable for all 5 cycles.
  - Stimulus: ack=1 with req=0.
  - Required: valid=0 next edge; ptr=3.
- Reset mid-hold:
  - Stimulus: valid=1, code=11; pulse rst_n low asynchronously between edges.
  - Required: valid=0, ptr=PTR_RESET immediately; the next capture after release starts the scan from PTR_RESET.
- Idle/spurious ack:
  - Stimulus: req=0000, ack=1 for 4 cycles.
  - Required: valid=0 and ptr unchanged.

Source files
------------

// File: rtl/rr_encoder_4x2.sv
// Registered 4-to-2 encoder with a valid/ack output handshake.
// It selects one request line using either round-robin or fixed priority.
module rr_encoder_4x2 #(
  parameter bit         ROUND_ROBIN = 1'b1,
  parameter logic [1:0] PTR_RESET   = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] code,
  output logic       valid,
  input  logic       ack,
  output logic       multi,
  output logic [1:0] ptr
);

  logic [1:0] code_reg, code_next;
  logic       valid_reg, valid_next;
  logic       multi_reg, multi_next;
  logic [1:0] ptr_reg, ptr_next;

  logic [3:0] rot_req;
  logic [1:0] rr_off;
  logic [1:0] rr_win;
  logic [1:0] fp_win;
  logic [1:0] win;
  logic       slot_free;
  logic       capture;
  logic       multi_now;

  // rot_req[gi] holds the request gi places after the current search start.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      logic [1:0] idx;
      assign idx         = ptr_reg + 2'(gi);
      assign rot_req[gi] = req[idx];
    end
  endgenerate

  always_comb begin
    rr_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) rr_off = 2'(i);
    end
    rr_win = ptr_reg + rr_off;
  end

  always_comb begin
    fp_win = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) fp_win = 2'(i);
    end
  end

  assign win       = ROUND_ROBIN ? rr_win : fp_win;
  assign multi_now = |(req & (req - 4'd1));
  assign slot_free = !valid_reg || ack;
  assign capture   = slot_free && (req != 4'b0000);

  always_comb begin
    code_next  = code_reg;
    valid_next = valid_reg;
    multi_next = multi_reg;
    ptr_next   = ptr_reg;
    if (capture) begin
      code_next  = win;
      multi_next = multi_now;
      valid_next = 1'b1;
      ptr_next   = ROUND_ROBIN ? (win + 2'd1) : PTR_RESET;
    end else if (valid_reg && ack) begin
      // Release: code and multi keep their stale values.
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_reg  <= 2'b00;
      valid_reg <= 1'b0;
      multi_reg <= 1'b0;
      ptr_reg   <= PTR_RESET;
    end else begin
      code_reg  <= code_next;
      valid_reg <= valid_next;
      multi_reg <= multi_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign code  = code_reg;
  assign valid = valid_reg;
  assign multi = multi_reg;
  assign ptr   = ptr_reg;

endmodule

// File: tb/tb_rr_encoder_4x2.sv
// Bench for rr_encoder_4x2: a round-robin instance and a fixed-priority instance share the stimulus.
// The vector table is checked through a scoreboard queue, and the async resets are checked directly.
module tb_rr_encoder_4x2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ack;
  logic [1:0] rr_code, fp_code;
  logic       rr_valid, fp_valid;
  logic       rr_multi, fp_multi;
  logic [1:0] rr_ptr, fp_ptr;

  rr_encoder_4x2 #(.ROUND_ROBIN(1'b1), .PTR_RESET(2'd0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .code(rr_code), .valid(rr_valid),
    .ack(ack), .multi(rr_multi), .ptr(rr_ptr)
  );

  rr_encoder_4x2 #(.ROUND_ROBIN(1'b0), .PTR_RESET(2'd2)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .code(fp_code), .valid(fp_valid),
    .ack(ack), .multi(fp_multi), .ptr(fp_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       valid;
    logic       care;   // code/multi are meaningful only when set
    logic [1:0] code;
    logic       multi;
    logic [1:0] ptr;
    logic [1:0] fp_code;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic a, input logic v, input logic c,
                     input logic [1:0] cd, input logic m, input logic [1:0] p, input logic [1:0] fc);
    vec_t t;
    t.req = r; t.ack = a; t.valid = v; t.care = c;
    t.code = cd; t.multi = m; t.ptr = p; t.fp_code = fc;
    vecs.push_back(t);
  endtask

  task automatic run(input int lo, input int hi);
    vec_t e;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      req = vecs[i].req;
      ack = vecs[i].ack;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard_empty at vec %0d", i);
      end else begin
        e = sb.pop_front();
        $display("[TB] vec %0d req=%b ack=%b -> rr code=%0d valid=%b multi=%b ptr=%0d | fp code=%0d",
                 i, e.req, e.ack, rr_code, rr_valid, rr_multi, rr_ptr, fp_code);
        check("rr_valid", 4'(rr_valid), 4'(e.valid));
        check("rr_ptr", 4'(rr_ptr), 4'(e.ptr));
        check("fp_valid", 4'(fp_valid), 4'(e.valid));
        check("fp_ptr", 4'(fp_ptr), 4'd2);
        if (e.care) begin
          check("rr_code", 4'(rr_code), 4'(e.code));
          check("rr_multi", 4'(rr_multi), 4'(e.multi));
          check("fp_code", 4'(fp_code), 4'(e.fp_code));
          check("fp_multi", 4'(fp_multi), 4'(e.multi));
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    $display("[TB] reset check %s: rr code=%0d valid=%b multi=%b ptr=%0d | fp ptr=%0d",
             tag, rr_code, rr_valid, rr_multi, rr_ptr, fp_ptr);
    check({tag, "_rr_valid"}, 4'(rr_valid), 4'd0);
    check({tag, "_rr_code"},  4'(rr_code),  4'd0);
    check({tag, "_rr_multi"}, 4'(rr_multi), 4'd0);
    check({tag, "_rr_ptr"},   4'(rr_ptr),   4'd0);
    check({tag, "_fp_valid"}, 4'(fp_valid), 4'd0);
    check({tag, "_fp_ptr"},   4'(fp_ptr),   4'd2);
  endtask

  // Reset pulse placed between clock edges; outputs must clear before any edge.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state(tag);
    req = 4'b0000;
    ack = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  int seg1_start, seg2_start;

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    ack   = 1'b0;

    // Pre-reset traffic that moves ptr away from its reset value.
    add(4'b0001, 1, 1, 1, 2'd0, 0, 2'd1, 2'd0);
    add(4'b0010, 1, 1, 1, 2'd1, 0, 2'd2, 2'd1);
    seg1_start = vecs.size();
    // Single-hot lines.
    add(4'b0001, 1, 1, 1, 2'd0, 0, 2'd1, 2'd0);
    add(4'b0010, 1, 1, 1, 2'd1, 0, 2'd2, 2'd1);
    add(4'b0100, 1, 1, 1, 2'd2, 0, 2'd3, 2'd2);
    add(4'b1000, 1, 1, 1, 2'd3, 0, 2'd0, 2'd3);
    // Round-robin fairness with all lines requesting.
    add(4'b1111, 1, 1, 1, 2'd0, 1, 2'd1, 2'd3);
    add(4'b1111, 1, 1, 1, 2'd1, 1, 2'd2, 2'd3);
    add(4'b1111, 1, 1, 1, 2'd2, 1, 2'd3, 2'd3);
    add(4'b1111, 1, 1, 1, 2'd3, 1, 2'd0, 2'd3);
    add(4'b1111, 1, 1, 1, 2'd0, 1, 2'd1, 2'd3);
    // Two lines requesting: the grants alternate.
    add(4'b1001, 1, 1, 1, 2'd3, 1, 2'd0, 2'd3);
    add(4'b1001, 1, 1, 1, 2'd0, 1, 2'd1, 2'd3);
    add(4'b1001, 1, 1, 1, 2'd3, 1, 2'd0, 2'd3);
    add(4'b1001, 1, 1, 1, 2'd0, 1, 2'd1, 2'd3);
    // Backpressure: capture, then hold for 5 cycles while req toggles.
    add(4'b0100, 1, 1, 1, 2'd2, 0, 2'd3, 2'd2);
    add(4'b0001, 0, 1, 1, 2'd2, 0, 2'd3, 2'd2);
    add(4'b1000, 0, 1, 1, 2'd2, 0, 2'd3, 2'd2);
    add(4'b0001, 0, 1, 1, 2'd2, 0, 2'd3, 2'd2);
    add(4'b1000, 0, 1, 1, 2'd2, 0, 2'd3, 2'd2);
    add(4'b0001, 0, 1, 1, 2'd2, 0, 2'd3, 2'd2);
    // Release, then spurious ack while idle.
    add(4'b0000, 1, 0, 0, 2'd0, 0, 2'd3, 2'd0);
    add(4'b0000, 1, 0, 0, 2'd0, 0, 2'd3, 2'd0);
    add(4'b0000, 1, 0, 0, 2'd0, 0, 2'd3, 2'd0);
    add(4'b0000, 1, 0, 0, 2'd0, 0, 2'd3, 2'd0);
    add(4'b0000, 1, 0, 0, 2'd0, 0, 2'd3, 2'd0);
    // Capture line 3, then hold it ahead of the mid-hold reset.
    add(4'b1000, 1, 1, 1, 2'd3, 0, 2'd0, 2'd3);
    add(4'b0001, 0, 1, 1, 2'd3, 0, 2'd0, 2'd3);
    seg2_start = vecs.size();
    // After reset the scan starts from PTR_RESET.
    add(4'b0110, 0, 1, 1, 2'd1, 1, 2'd2, 2'd2);
    // Fixed priority picks line 3 every time; round-robin alternates.
    add(4'b1010, 1, 1, 1, 2'd3, 1, 2'd0, 2'd3);
    add(4'b1010, 1, 1, 1, 2'd1, 1, 2'd2, 2'd3);
    add(4'b1010, 1, 1, 1, 2'd3, 1, 2'd0, 2'd3);
    add(4'b0000, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0);

    // Power-on reset, asserted asynchronously before the first clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, seg1_start - 1);
    mid_reset("midrun");
    run(seg1_start, seg2_start - 1);
    mid_reset("midhold");
    run(seg2_start, vecs.size() - 1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
